timer_compare_bank: RTL
=======================

TIMER_COMPARE_BANK -- requirements
Module: timer_compare_bank

Interface
REQ-001 Parameter WIDTH, default 32: width of the counter, compare, period and data bus.
REQ-002 Parameter CHANNELS, default 4: number of independent compare channels (1..16).
REQ-003 Parameter ADDR_W, default 4: register address width; the block SHALL use only the low clog2(CHANNELS)+2 bits.
REQ-004 Reset rst is asynchronous and active-high; the clock is clk.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 count_en  input  1  counter increments this cycle.
REQ-008 count_we  input  1  load the counter from count_wdata.
REQ-009 count_wdata  input  WIDTH  counter load value.
REQ-010 count  output  WIDTH  current counter value.
REQ-011 we  input  1  register write strobe.
REQ-012 addr  input  ADDR_W  register select: {channel, reg}; reg 0=COMPARE, 1=PERIOD, 2=CTRL, 3=STATUS.
REQ-013 wdata  input  WIDTH  register write data.
REQ-014 rdata  output  WIDTH  combinational read of the register selected by addr.
REQ-015 irq  output  CHANNELS  per-channel interrupt, pending AND ie.
REQ-016 irq_any  output  1  OR of irq.

Function
REQ-017 The counter SHALL load count_wdata when count_we=1, otherwise increment by 1 when count_en=1 (wrapping 2^WIDTH-1 -> 0), otherwise hold.
REQ-018 Per channel: COMPARE (WIDTH), PERIOD (WIDTH), CTRL{bit0 mode: 0 one-shot, 1 periodic; bit1 ie}, internal armed flag, STATUS{bit0 pending}.
REQ-019 Match SHALL be registered count == COMPARE while armed=1; the resulting pending is visible the following cycle.
REQ-020 One-shot match: set pending, clear armed; no further match until COMPARE is rewritten.
REQ-021 Periodic match: set pending, COMPARE <= COMPARE + PERIOD modulo 2^WIDTH, armed stays 1.
REQ-022 Writing COMPARE SHALL load wdata, set armed=1, clear pending; this takes priority over a same-cycle match on that channel.
REQ-023 Writing STATUS with bit0=1 clears pending; a same-cycle match SHALL win (pending stays 1).
REQ-024 Writing PERIOD or CTRL SHALL NOT alter pending or armed; the new value applies from the next match.
REQ-025 Accesses to a channel index >= CHANNELS SHALL be ignored on write and read as 0; CTRL/STATUS unused bits read 0.
REQ-026 PERIOD=0 in periodic mode SHALL re-match every cycle while count is unchanged.
REQ-027 count_we and a match in the same cycle: the match uses the pre-load count value.

Reset
REQ-028 On rst: count=0, every COMPARE=all ones, PERIOD=0, CTRL=0, armed=1, pending=0, so irq=0 and irq_any=0.
REQ-029 Reset mid-operation SHALL discard all pending and in-progress periodic reloads immediately.

Structure
REQ-030 Shared package SHALL hold the register offset constants (REG_COMPARE..REG_STATUS) and CTRL bit positions.
REQ-031 One sub-module, timer_compare_chan, SHALL implement one channel (compare/period/ctrl/armed/pending) and be generated CHANNELS times; the top holds the counter, address decode and read mux.

Verification
REQ-032 Reset, no writes, count_en=1 for 20 cycles -> count=20, irq=0, COMPARE reads 0xFFFFFFFF.
REQ-033 Ch0 one-shot, ie=1, COMPARE=10, count_en=1 from count 0 -> irq[0]=1 the cycle after count=10; rewinding count via count_we=5 gives no second irq; STATUS write 1 -> irq[0]=0.
REQ-034 Ch1 periodic, COMPARE=4, PERIOD=8, ie=1, clear pending after each match -> pending at counts 4, 12, 20; COMPARE reads 12 after the first match.
REQ-035 Ch2 periodic, COMPARE=0xFFFFFFFC, PERIOD=8 -> after the match COMPARE=0x00000004 (wrap), next match after counter wrap.
REQ-036 Same cycle: count==COMPARE on ch3 with a COMPARE write of 50 -> pending=0, COMPARE=50; separately match + STATUS clear -> pending=1.
REQ-037 Ch0 ie=0 with match -> STATUS pending=1, irq[0]=0; then set ie=1 -> irq[0]=1 and irq_any=1 next cycle.

Source files
------------

// File: rtl/timer_compare_bank_pkg.sv
// Shared register map and control-bit layout for the timer compare bank.
package timer_compare_bank_pkg;

  typedef enum logic [1:0] {
    REG_COMPARE = 2'd0,
    REG_PERIOD  = 2'd1,
    REG_CTRL    = 2'd2,
    REG_STATUS  = 2'd3
  } reg_sel_e;

  localparam int unsigned CTRL_W             = 2;
  localparam int unsigned CTRL_MODE_BIT      = 0;  // 0 one-shot, 1 periodic
  localparam int unsigned CTRL_IE_BIT        = 1;
  localparam int unsigned STATUS_PENDING_BIT = 0;

endpackage

// File: rtl/timer_compare_chan.sv
// One compare channel: COMPARE/PERIOD/CTRL registers plus armed and pending state.
module timer_compare_chan
  import timer_compare_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  count,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              we_compare,
  input  logic              we_period,
  input  logic              we_ctrl,
  input  logic              we_status,
  output logic [WIDTH-1:0]  compare,
  output logic [WIDTH-1:0]  period,
  output logic [CTRL_W-1:0] ctrl,
  output logic              pending,
  output logic              irq
);

  logic armed;
  logic match;

  assign match = armed && (count == compare);
  assign irq   = pending && ctrl[CTRL_IE_BIT];

  // COMPARE write beats a match; a match beats a STATUS clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare <= '1;
      period  <= '0;
      ctrl    <= '0;
      armed   <= 1'b1;
      pending <= 1'b0;
    end else begin
      if (we_period) period <= wdata;
      if (we_ctrl)   ctrl   <= wdata[CTRL_W-1:0];
      if (we_compare) begin
        compare <= wdata;
        armed   <= 1'b1;
        pending <= 1'b0;
      end else if (match) begin
        pending <= 1'b1;
        if (ctrl[CTRL_MODE_BIT]) compare <= compare + period;
        else                     armed   <= 1'b0;
      end else if (we_status && wdata[STATUS_PENDING_BIT]) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/timer_compare_bank.sv
// Free-running counter shared by a bank of compare channels with a small register file.
module timer_compare_bank
  import timer_compare_bank_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                count_en,
  input  logic                count_we,
  input  logic [WIDTH-1:0]    count_wdata,
  output logic [WIDTH-1:0]    count,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [WIDTH-1:0]    wdata,
  output logic [WIDTH-1:0]    rdata,
  output logic [CHANNELS-1:0] irq,
  output logic                irq_any
);

  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned USED_W = $clog2(CHANNELS) + 2;

  reg_sel_e        reg_sel;
  logic [CH_W-1:0] chan_sel;
  int unsigned     chan_idx;
  logic            chan_ok;

  logic [WIDTH-1:0]  compare_r [CHANNELS];
  logic [WIDTH-1:0]  period_r  [CHANNELS];
  logic [CTRL_W-1:0] ctrl_r    [CHANNELS];
  logic [CHANNELS-1:0] pending_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           count <= '0;
    else if (count_we) count <= count_wdata;
    else if (count_en) count <= count + WIDTH'(1);
  end

  // A single-channel bank has no channel field, so only addr[1:0] is decoded.
  always_comb begin
    reg_sel  = reg_sel_e'(addr[1:0]);
    chan_sel = '0;
    if (CHANNELS > 1) chan_sel = addr[CH_W+1:2];
    chan_idx = 32'(chan_sel);
    chan_ok  = chan_idx < CHANNELS;
  end

  if (ADDR_W > USED_W) begin : g_unused_addr
    logic unused_addr;
    assign unused_addr = ^addr[ADDR_W-1:USED_W];
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic sel;
    assign sel = we && chan_ok && (chan_idx == i);

    timer_compare_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .count      (count),
      .wdata      (wdata),
      .we_compare (sel && (reg_sel == REG_COMPARE)),
      .we_period  (sel && (reg_sel == REG_PERIOD)),
      .we_ctrl    (sel && (reg_sel == REG_CTRL)),
      .we_status  (sel && (reg_sel == REG_STATUS)),
      .compare    (compare_r[i]),
      .period     (period_r[i]),
      .ctrl       (ctrl_r[i]),
      .pending    (pending_r[i]),
      .irq        (irq[i])
    );
  end

  always_comb begin
    rdata = '0;
    if (chan_ok) begin
      case (reg_sel)
        REG_COMPARE: rdata = compare_r[chan_sel];
        REG_PERIOD:  rdata = period_r[chan_sel];
        REG_CTRL:    rdata = WIDTH'(ctrl_r[chan_sel]);
        REG_STATUS:  rdata = WIDTH'(pending_r[chan_sel]);
        default:     rdata = '0;
      endcase
    end
  end

  assign irq_any = |irq;

endmodule
